// File: rtl/adc_link_sequencer_if.sv
// adc_link_sequencer_if: capture request/stream bundle (trig, cap_len, cap_ready in; cap_valid, cap_last out of the sequencer)
interface adc_link_sequencer_if;
  logic        trig;
  logic [15:0] cap_len;
  logic        cap_ready;
  logic        cap_valid;
  logic        cap_last;
  modport master(output trig, cap_len, cap_ready, input cap_valid, cap_last);
  modport slave(input trig, cap_len, cap_ready, output cap_valid, cap_last);
endinterface

// File: rtl/adc_link_sequencer.sv
// adc_link_sequencer: ADC bring-up (reset/align/retry/fail) and capture sequencer on CLKDIV with sync active-low rst_n; ports start, aligned, cap (if), adc_rst, adc_en, link_up, fail, overrun, state_o; ADC_LINK_SEQUENCER_REALIGN_EN enables relock on lost alignment
module adc_link_sequencer #(
  parameter int RST_HOLD      = 16,
  parameter int ALIGN_TIMEOUT = 1024,
  parameter int ALIGN_STABLE  = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                    CLKDIV,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    aligned,
  adc_link_sequencer_if.slave     cap,
  output logic                    adc_rst,
  output logic                    adc_en,
  output logic                    link_up,
  output logic                    fail,
  output logic                    overrun,
  output logic [2:0]              state_o
);
  localparam int RW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(ALIGN_TIMEOUT + 1);
  localparam int SW = $clog2(ALIGN_STABLE + 1);
  localparam int NW = $clog2(MAX_RETRIES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, RESET = 3'd1, ALIGN = 3'd2, READY = 3'd3, CAPTURE = 3'd4, FAIL = 3'd5} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [NW-1:0] retry_q, retry_d;
  logic [15:0] len_q, len_d, smp_q, smp_d;
  logic valid_q, valid_d, last_q, last_d, ovr_q, ovr_d;
  logic adc_rst_q, adc_rst_d, adc_en_q, adc_en_d, link_q, link_d, fail_q, fail_d;
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stab_d    = stab_q;
    retry_d   = retry_q;
    len_d     = len_q;
    smp_d     = smp_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    ovr_d     = ovr_q;
    case (state_q)
      IDLE, FAIL: if (start) begin
        state_d   = RESET;
        rst_cnt_d = '0;
        retry_d   = '0;
        ovr_d     = 1'b0;
      end
      RESET: if (rst_cnt_q == RW'(RST_HOLD - 1)) begin
        state_d  = ALIGN;
        to_cnt_d = '0;
        stab_d   = '0;
      end else rst_cnt_d = rst_cnt_q + RW'(1);
      ALIGN: begin
        to_cnt_d = to_cnt_q + TW'(1);
        stab_d   = aligned ? stab_q + SW'(1) : '0;
        if (aligned && stab_q == SW'(ALIGN_STABLE - 1)) state_d = READY;
        else if (to_cnt_q == TW'(ALIGN_TIMEOUT - 1)) begin
          retry_d   = retry_q + NW'(1);
          rst_cnt_d = '0;
          state_d   = (retry_q + NW'(1) < NW'(MAX_RETRIES)) ? RESET : FAIL;
        end
      end
      READY: if (cap.trig && cap.cap_len != 16'd0) begin
        state_d = CAPTURE;
        len_d   = cap.cap_len;
        smp_d   = 16'd1;
        valid_d = 1'b1;
        last_d  = cap.cap_len == 16'd1;
      end
      CAPTURE: if (!cap.cap_ready) begin
        ovr_d   = 1'b1;
        state_d = READY;
      end else if (smp_q == len_q) state_d = READY;
      else begin
        smp_d   = smp_q + 16'd1;
        valid_d = 1'b1;
        last_d  = smp_q + 16'd1 == len_q;
      end
      default: state_d = IDLE;
    endcase
`ifdef ADC_LINK_SEQUENCER_REALIGN_EN
    if ((state_q == READY || state_q == CAPTURE) && !aligned) begin
      state_d   = RESET;
      rst_cnt_d = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
    end
`endif
    adc_rst_d = state_d == IDLE || state_d == RESET || state_d == FAIL;
    adc_en_d  = state_d == ALIGN || state_d == READY || state_d == CAPTURE;
    link_d    = state_d == READY || state_d == CAPTURE;
    fail_d    = state_d == FAIL;
  end
  always_ff @(posedge CLKDIV) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      len_q     <= '0;
      smp_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ovr_q     <= 1'b0;
      adc_rst_q <= 1'b1;
      adc_en_q  <= 1'b0;
      link_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      len_q     <= len_d;
      smp_q     <= smp_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ovr_q     <= ovr_d;
      adc_rst_q <= adc_rst_d;
      adc_en_q  <= adc_en_d;
      link_q    <= link_d;
      fail_q    <= fail_d;
    end
  end
  assign cap.cap_valid = valid_q;
  assign cap.cap_last  = last_q;
  assign adc_rst       = adc_rst_q;
  assign adc_en        = adc_en_q;
  assign link_up       = link_q;
  assign fail          = fail_q;
  assign overrun       = ovr_q;
  assign state_o       = state_q;
endmodule
